// File: rtl/conv3x3_window_sequencer.sv
// Address/strobe sequencer for a 3x3 convolution datapath: walks every valid
// window of the frame, issues 9 pixel/weight reads per output pixel and flags
// each completed accumulator sum with its output coordinates.
module conv3x3_window_sequencer #(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              hold_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pix_rd_en_o,
    output logic [ADDR_W-1:0] pix_addr_o,
    output logic [3:0]        w_addr_o,
    output logic              acc_valid_o,
    output logic              res_valid_o,
    output logic [7:0]        res_x_o,
    output logic [7:0]        res_y_o
);

    localparam logic [7:0] OxLast = 8'(IMG_W - 3);
    localparam logic [7:0] OyLast = 8'(IMG_H - 3);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e     state_q, state_d;
    logic [1:0] kx_q, kx_d, ky_q, ky_d;
    logic [7:0] ox_q, ox_d, oy_q, oy_d;

    logic       issue, win_end, frame_end;

    // Two-stage pipeline matching the 1-cycle read latency plus the accumulator stage.
    logic       acc_valid_q, last1_q, res_valid_q;
    logic [7:0] x1_q, y1_q, res_x_q, res_y_q;

    logic [ADDR_W-1:0] row, col;

    // Tap issue and window/frame boundary decode from the current counters.
    always_comb begin
        issue     = (state_q == StRun) && !hold_i;
        win_end   = (kx_q == 2'd2) && (ky_q == 2'd2);
        frame_end = win_end && (ox_q == OxLast) && (oy_q == OyLast);
    end

    // Next-state and counter advance; kx fastest, then ky, ox, oy.
    always_comb begin
        state_d = state_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    kx_d    = 2'd0;
                    ky_d    = 2'd0;
                    ox_d    = 8'd0;
                    oy_d    = 8'd0;
                end
            end
            StRun: begin
                if (!hold_i) begin
                    if (kx_q != 2'd2) begin
                        kx_d = kx_q + 2'd1;
                    end else begin
                        kx_d = 2'd0;
                        if (ky_q != 2'd2) begin
                            ky_d = ky_q + 2'd1;
                        end else begin
                            ky_d = 2'd0;
                            if (ox_q != OxLast) begin
                                ox_d = ox_q + 8'd1;
                            end else begin
                                ox_d = 8'd0;
                                oy_d = (oy_q == OyLast) ? 8'd0 : oy_q + 8'd1;
                            end
                        end
                    end
                    if (frame_end) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Only the final window's sum can still be in flight here.
                if (res_valid_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            kx_q    <= 2'd0;
            ky_q    <= 2'd0;
            ox_q    <= 8'd0;
            oy_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
        end
    end

    // Strobe and coordinate pipeline; hold never stalls taps already issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_valid_q <= 1'b0;
            last1_q     <= 1'b0;
            res_valid_q <= 1'b0;
            x1_q        <= 8'd0;
            y1_q        <= 8'd0;
            res_x_q     <= 8'd0;
            res_y_q     <= 8'd0;
        end else begin
            acc_valid_q <= issue;
            last1_q     <= issue && win_end;
            res_valid_q <= last1_q;
            if (issue && win_end) begin
                x1_q <= ox_q;
                y1_q <= oy_q;
            end
            if (last1_q) begin
                res_x_q <= x1_q;
                res_y_q <= y1_q;
            end
        end
    end

    // Output decode; addresses follow the counters directly.
    always_comb begin
        row         = ADDR_W'(oy_q) + ADDR_W'(ky_q);
        col         = ADDR_W'(ox_q) + ADDR_W'(kx_q);
        pix_addr_o  = row * ADDR_W'(IMG_W) + col;
        w_addr_o    = {2'b00, ky_q} * 4'd3 + {2'b00, kx_q};
        pix_rd_en_o = issue;
        busy_o      = (state_q != StIdle);
        done_o      = (state_q == StDrain) && res_valid_q;
        acc_valid_o = acc_valid_q;
        res_valid_o = res_valid_q;
        res_x_o     = res_x_q;
        res_y_o     = res_y_q;
    end

endmodule

// File: tb/tb_conv3x3_window_sequencer.sv
// Self-checking bench: an 8x8 instance checked cycle by cycle against a
// tap-index reference model, plus a 3x3 instance with directed checks.
module tb_conv3x3_window_sequencer;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NW   = W - 2;
    localparam int NTAP = (W - 2) * (H - 2) * 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, hold = 1'b0;
    logic       busy, done, rd_en, accv, resv;
    logic [5:0] addr;
    logic [3:0] waddr;
    logic [7:0] rx, ry;

    logic       start3 = 1'b0, hold3 = 1'b0;
    logic       busy3, done3, rd3, accv3, resv3;
    logic [3:0] addr3, waddr3;
    logic [7:0] rx3, ry3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv3x3_window_sequencer #(.IMG_W(8), .IMG_H(8), .ADDR_W(6)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .hold_i(hold),
        .busy_o(busy), .done_o(done), .pix_rd_en_o(rd_en), .pix_addr_o(addr),
        .w_addr_o(waddr), .acc_valid_o(accv), .res_valid_o(resv),
        .res_x_o(rx), .res_y_o(ry)
    );

    conv3x3_window_sequencer #(.IMG_W(3), .IMG_H(3), .ADDR_W(4)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .hold_i(hold3),
        .busy_o(busy3), .done_o(done3), .pix_rd_en_o(rd3), .pix_addr_o(addr3),
        .w_addr_o(waddr3), .acc_valid_o(accv3), .res_valid_o(resv3),
        .res_x_o(rx3), .res_y_o(ry3)
    );

    // Reference model state: frame activity and tap index, with the two most
    // recent cycles' issue history (read latency 1, sum flag latency 2).
    bit m_busy = 0;
    int m_issued = 0;
    bit h1_v = 0, h2_v = 0;
    int h1_i = 0, h2_i = 0;

    int cyc, issue_cnt, res_cnt, first_res_cyc, done_cyc;
    int last_rx, last_ry;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int idx);
        int win, tap;
        win = idx / 9;
        tap = idx % 9;
        return ((win / NW) + tap / 3) * W + (win % NW) + tap % 3;
    endfunction

    function automatic bit next_done();
        return h2_v && (h2_i == NTAP - 1);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_issued = 0;
        h1_v = 0; h2_v = 0; h1_i = 0; h2_i = 0;
    endtask

    task automatic step(input bit start_v, input bit hold_v);
        bit e_issue, e_res, e_done;
        int idx, win;
        @(posedge clk);
        #1;
        start = start_v;
        hold  = hold_v;
        cyc++;
        @(negedge clk);
        e_issue = m_busy && (m_issued < NTAP) && !hold_v;
        idx     = m_issued;
        e_res   = h2_v && (h2_i % 9 == 8);
        e_done  = e_res && (h2_i == NTAP - 1);
        chk("busy", busy, m_busy);
        chk("pix_rd_en", rd_en, e_issue);
        chk("acc_valid", accv, h1_v);
        chk("res_valid", resv, e_res);
        chk("done", done, e_done);
        if (e_issue) begin
            chk("pix_addr", addr, exp_addr(idx));
            chk("w_addr", waddr, idx % 9);
            issue_cnt++;
        end
        if (e_res) begin
            win = h2_i / 9;
            chk("res_x", rx, win % NW);
            chk("res_y", ry, win / NW);
        end
        if (resv) begin
            res_cnt++;
            last_rx = rx;
            last_ry = ry;
            if (first_res_cyc < 0) first_res_cyc = cyc;
        end
        if (done) done_cyc = cyc;
        h2_v = h1_v; h2_i = h1_i;
        h1_v = e_issue; h1_i = idx;
        if (e_issue) m_issued++;
        if (!m_busy && start_v) begin
            m_busy = 1;
            m_issued = 0;
        end else if (e_done) begin
            m_busy = 0;
        end
    endtask

    // Starts a frame (start driven in cycle 0) and runs it to completion.
    // hold_mode: 0 none, 1 hold cycles 5..7, 2 as 1 plus random holds.
    task automatic run_frame(input int hold_mode, input bit poke, input int abort_at);
        bit hv, sv;
        int n;
        cyc = -1; issue_cnt = 0; res_cnt = 0; first_res_cyc = -1; done_cyc = -1;
        step(1'b1, 1'b0);
        n = 0;
        while ((m_busy || cyc < 1) && n < 2000) begin
            if (abort_at >= 0 && m_issued >= abort_at) return;
            hv = (hold_mode >= 1) && (cyc + 1 >= 5) && (cyc + 1 <= 7);
            if (hold_mode == 2 && cyc > 20 && $urandom_range(3, 0) == 0) hv = 1'b1;
            sv = poke && ((cyc + 1 == 50) || (cyc + 1 == 200) || next_done());
            step(sv, hv);
            n++;
        end
        chk("frame_timeout", {31'd0, m_busy}, 0);
        // Idle cycles after done: a start pulsed on the done cycle must not restart.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    endtask

    task automatic chk_zero8(input string tag);
        chk(tag, {busy, done, rd_en, addr, waddr, accv, resv, rx, ry}, 0);
    endtask

    task automatic chk_zero3(input string tag);
        chk(tag, {busy3, done3, rd3, addr3, waddr3, accv3, resv3, rx3, ry3}, 0);
    endtask

    initial begin
        int n3, rc3, dc3, rxs, rys;

        // Reset state.
        repeat (2) @(negedge clk);
        chk_zero8("reset_outputs");
        chk_zero3("reset_outputs_3x3");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Frame A: no stalls, start re-pulsed during RUN and on the done cycle.
        run_frame(0, 1'b1, -1);
        chk("A_issue_count", issue_cnt, NTAP);
        chk("A_res_count", res_cnt, 36);
        chk("A_first_res_cycle", first_res_cyc, 11);
        chk("A_done_cycle", done_cyc, NTAP + 2);
        chk("A_last_res_xy", {last_rx[7:0], last_ry[7:0]}, {8'd5, 8'd5});
        chk("A_idle_after", busy, 0);

        // Frame B: 3-cycle hold after tap 4 of window (0,0), then random stalls.
        run_frame(2, 1'b0, -1);
        chk("B_issue_count", issue_cnt, NTAP);
        chk("B_res_count", res_cnt, 36);
        chk("B_first_res_cycle", first_res_cyc, 14);

        // Frame C: aborted by reset inside window (2,1), i.e. window index 8.
        run_frame(0, 1'b0, 8 * 9 + 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero8("midframe_reset_outputs");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Frame D after abort: restarts at window (0,0), random stalls.
        run_frame(2, 1'b0, -1);
        chk("D_issue_count", issue_cnt, NTAP);
        chk("D_res_count", res_cnt, 36);

        // 3x3 instance: 9 issues, one result (0,0) together with done in cycle 11.
        @(posedge clk);
        #1 start3 = 1'b1;
        n3 = 0; rc3 = -1; dc3 = -1; rxs = -1; rys = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1 start3 = 1'b0;
            @(negedge clk);
            if (rd3) n3++;
            if (resv3) begin
                rc3 = c; rxs = rx3; rys = ry3;
            end
            if (done3) dc3 = c;
        end
        chk("3x3_issue_count", n3, 9);
        chk("3x3_res_cycle", rc3, 11);
        chk("3x3_done_cycle", dc3, 11);
        chk("3x3_res_xy", {rxs[7:0], rys[7:0]}, 0);
        chk("3x3_idle_after", busy3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
